my_matrix_multiplier_example_counter_bank: RTL

Bank of C_NUM_CH independent up/down counters for matrix-multiplier address and loop control. Each channel has a programmable step, an upper limit, and a saturate-or-wrap mode. Registered zero and limit flags plus a one-cycle wrap pulse let the kernel sequencers chain row, column and tile loops without extra compare logic.

---
 rtl/my_matrix_multiplier_example_counter_bank_pkg.sv | 91 +++++++++
 rtl/my_matrix_multiplier_example_counter_bank_if.sv | 33 +++
 rtl/my_matrix_multiplier_example_counter_ch.sv | 64 ++++++
 rtl/my_matrix_multiplier_example_counter_bank.sv | 41 ++++
 4 files changed

// File: rtl/my_matrix_multiplier_example_counter_bank_pkg.sv
// Counter bank shared types: per-channel op decode and
// the widened wrap/saturate next-count computation.
package my_matrix_multiplier_example_counter_bank_pkg;

    // Widest count supported; math runs one bit wider.
    localparam int unsigned MAX_W = 32;

    typedef logic [MAX_W:0] wide_t;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } op_e;

    typedef struct packed {
        wide_t cnt;
        logic  wrap;
    } upd_t;

    function automatic op_e decode_op(
        input logic clr,
        input logic load,
        input logic incr,
        input logic decr
    );
        op_e op;
        if (clr)
            op = OP_CLR;
        else if (load)
            op = OP_LOAD;
        else if (incr && !decr)
            op = OP_INC;
        else if (decr && !incr)
            op = OP_DEC;
        else
            op = OP_HOLD;
        return op;
    endfunction

    // span = limit+1; a step wider than span cannot wrap
    // with a single correction, so it saturates instead.
    function automatic upd_t calc_next(
        input op_e   op,
        input wide_t cnt,
        input wide_t lim,
        input wide_t stp,
        input wide_t ld,
        input wide_t init,
        input logic  sat
    );
        upd_t  r;
        wide_t span;
        span   = lim + 1'b1;
        r.cnt  = cnt;
        r.wrap = 1'b0;
        unique case (op)
            OP_CLR:  r.cnt = init;
            OP_LOAD: r.cnt = (ld > lim) ? lim : ld;
            OP_INC: begin
                if (stp == '0)
                    r.cnt = cnt;
                else if (cnt + stp <= lim)
                    r.cnt = cnt + stp;
                else if (sat || stp > span)
                    r.cnt = lim;
                else begin
                    r.cnt  = cnt + stp - span;
                    r.wrap = 1'b1;
                end
            end
            OP_DEC: begin
                if (stp == '0)
                    r.cnt = cnt;
                else if (stp <= cnt)
                    r.cnt = cnt - stp;
                else if (sat || stp > span)
                    r.cnt = '0;
                else begin
                    r.cnt  = cnt + span - stp;
                    r.wrap = 1'b1;
                end
            end
            default: r.cnt = cnt;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/my_matrix_multiplier_example_counter_bank_if.sv
// Control and status bus of the counter bank.
// master drives the strobes, slave is the bank.
interface my_matrix_multiplier_example_counter_bank_if #(
    parameter int C_NUM_CH     = 4,
    parameter int C_WIDTH      = 16,
    parameter int C_STEP_WIDTH = 4
) ();
    logic                            clken;
    logic [C_NUM_CH-1:0]             clr;
    logic [C_NUM_CH-1:0]             load;
    logic [C_NUM_CH-1:0]             incr;
    logic [C_NUM_CH-1:0]             decr;
    logic [C_NUM_CH-1:0]             sat_en;
    logic [C_NUM_CH*C_WIDTH-1:0]     load_value;
    logic [C_NUM_CH*C_STEP_WIDTH-1:0] step;
    logic [C_NUM_CH*C_WIDTH-1:0]     limit;
    logic [C_NUM_CH*C_WIDTH-1:0]     count;
    logic [C_NUM_CH-1:0]             is_zero;
    logic [C_NUM_CH-1:0]             at_limit;
    logic [C_NUM_CH-1:0]             wrap;

    modport master (
        output clken, clr, load, incr, decr, sat_en,
        output load_value, step, limit,
        input  count, is_zero, at_limit, wrap
    );

    modport slave (
        input  clken, clr, load, incr, decr, sat_en,
        input  load_value, step, limit,
        output count, is_zero, at_limit, wrap
    );
endinterface

// File: rtl/my_matrix_multiplier_example_counter_ch.sv
// One up/down counter channel with step, limit,
// saturate/wrap mode and registered flags.
module my_matrix_multiplier_example_counter_ch
    import my_matrix_multiplier_example_counter_bank_pkg::*;
#(
    parameter int                 C_WIDTH      = 16,
    parameter int                 C_STEP_WIDTH = 4,
    parameter logic [C_WIDTH-1:0] C_INIT       = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clken,
    input  logic                    clr,
    input  logic                    load,
    input  logic                    incr,
    input  logic                    decr,
    input  logic                    sat_en,
    input  logic [C_WIDTH-1:0]      load_value,
    input  logic [C_STEP_WIDTH-1:0] step,
    input  logic [C_WIDTH-1:0]      limit,
    output logic [C_WIDTH-1:0]      count,
    output logic                    is_zero,
    output logic                    at_limit,
    output logic                    wrap
);

    op_e                op;
    upd_t               upd;
    logic [C_WIDTH-1:0] cnt_d;
    logic               hi_unused;

    // Decode the op and compute the widened next count.
    always_comb begin
        op  = decode_op(clr, load, incr, decr);
        upd = calc_next(op,
                        wide_t'(count),
                        wide_t'(limit),
                        wide_t'(step),
                        wide_t'(load_value),
                        wide_t'(C_INIT),
                        sat_en);
    end

    assign cnt_d     = upd.cnt[C_WIDTH-1:0];
    assign hi_unused = ^upd.cnt[MAX_W:C_WIDTH];

    // Count and flags update together; wrap is a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= C_INIT;
            is_zero  <= (C_INIT == '0);
            at_limit <= 1'b0;
            wrap     <= 1'b0;
        end else if (clken) begin
            count    <= cnt_d;
            is_zero  <= (cnt_d == '0);
            at_limit <= (cnt_d == limit);
            wrap     <= upd.wrap;
        end else begin
            wrap     <= 1'b0;
        end
    end

endmodule

// File: rtl/my_matrix_multiplier_example_counter_bank.sv
// Bank of independent loop/address counters; each
// channel slices its fields out of the packed bus.
module my_matrix_multiplier_example_counter_bank
    import my_matrix_multiplier_example_counter_bank_pkg::*;
#(
    parameter int                 C_NUM_CH     = 4,
    parameter int                 C_WIDTH      = 16,
    parameter int                 C_STEP_WIDTH = 4,
    parameter logic [C_WIDTH-1:0] C_INIT       = '0
) (
    input logic clk,
    input logic rst_n,
    my_matrix_multiplier_example_counter_bank_if.slave bus
);

    // One counter per channel; no cross-channel carry.
    for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
        my_matrix_multiplier_example_counter_ch #(
            .C_WIDTH      (C_WIDTH),
            .C_STEP_WIDTH (C_STEP_WIDTH),
            .C_INIT       (C_INIT)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .clken      (bus.clken),
            .clr        (bus.clr[i]),
            .load       (bus.load[i]),
            .incr       (bus.incr[i]),
            .decr       (bus.decr[i]),
            .sat_en     (bus.sat_en[i]),
            .load_value (bus.load_value[i*C_WIDTH +: C_WIDTH]),
            .step       (bus.step[i*C_STEP_WIDTH +: C_STEP_WIDTH]),
            .limit      (bus.limit[i*C_WIDTH +: C_WIDTH]),
            .count      (bus.count[i*C_WIDTH +: C_WIDTH]),
            .is_zero    (bus.is_zero[i]),
            .at_limit   (bus.at_limit[i]),
            .wrap       (bus.wrap[i])
        );
    end

endmodule
